wb_port_arbiter: RTL

- Shares the single register-file write port between two requesters:
  - the in-order pipeline writeback path (the WB stage's rd index/data, one instruction per cycle);
  - the out-of-order results of the multi-cycle mul/div unit.
- Mul/div results are buffered in a small FIFO, so the pipeline stalls only when the buffer must be drained.
- Sits between the WB stage and the regfile write port. Also exports a pending-destination hit for hazard detection.

---
 rtl/wb_port_arbiter_pkg.sv | 13 +
 rtl/wb_md_fifo.sv | 65 ++++++
 rtl/wb_port_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_pkg.sv
// Shared constants and state encoding for the writeback-port arbiter.
// Sizes the register index and default data width used by the arbiter and its FIFO.
package wb_port_arbiter_pkg;

  localparam int DEF_XLEN  = 64;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    ST_NORMAL = 1'b0,
    ST_DRAIN  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/wb_md_fifo.sv
// Synchronous FIFO for buffered mul/div results, with a destination-index probe
// over all live entries so hazard logic can see pending writes.
module wb_md_fifo
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [REG_IDX_W-1:0]    push_idx,
  input  logic [DW-1:0]           push_data,
  input  logic                    pop,
  output logic [REG_IDX_W-1:0]    head_idx,
  output logic [DW-1:0]           head_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  input  logic [REG_IDX_W-1:0]    chk_idx,
  output logic                    chk_hit
);

  localparam int AW = $clog2(DEPTH);

  logic [REG_IDX_W-1:0] idx_mem  [DEPTH];
  logic [DW-1:0]        data_mem [DEPTH];
  logic [AW:0]          wptr;
  logic [AW:0]          rptr;
  logic [AW-1:0]        offs;

  assign count     = wptr - rptr;
  assign empty     = (wptr == rptr);
  assign full      = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign head_idx  = idx_mem[rptr[AW-1:0]];
  assign head_data = data_mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      idx_mem[wptr[AW-1:0]]  <= push_idx;
      data_mem[wptr[AW-1:0]] <= push_data;
    end
  end

  // An entry is live when its distance from the read pointer is below the fill count.
  always_comb begin
    chk_hit = 1'b0;
    offs    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offs = AW'(i) - rptr[AW-1:0];
      if (({1'b0, offs} < count) && (idx_mem[i] == chk_idx)) chk_hit = 1'b1;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single regfile write port between the in-order WB stage and
// buffered mul/div results, stalling the pipe only when the buffer must drain.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int XLEN         = DEF_XLEN,
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pipe_valid_i,
  input  logic                 pipe_wen_i,
  input  logic [REG_IDX_W-1:0] pipe_rd_idx_i,
  input  logic [XLEN-1:0]      pipe_rd_data_i,
  output logic                 pipe_stall_o,
  input  logic                 md_valid_i,
  output logic                 md_ready_o,
  input  logic [REG_IDX_W-1:0] md_rd_idx_i,
  input  logic [XLEN-1:0]      md_rd_data_i,
  output logic                 rf_wen_o,
  output logic [REG_IDX_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]      rf_wdata_o,
  input  logic [REG_IDX_W-1:0] chk_idx_i,
  output logic                 chk_hit_o,
  output logic                 md_busy_o
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);

  arb_state_e state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;

  logic                    pipe_req, md_nz, md_in, starved, drain;
  logic                    grant_head, grant_pipe, bypass, push;
  logic [REG_IDX_W-1:0]    head_idx;
  logic [XLEN-1:0]         head_data;
  logic                    fifo_full, fifo_empty, fifo_hit;
  logic [$clog2(DEPTH):0]  fifo_count;

  wb_md_fifo #(.DEPTH(DEPTH), .DW(XLEN)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_idx  (md_rd_idx_i),
    .push_data (md_rd_data_i),
    .pop       (grant_head),
    .head_idx  (head_idx),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .chk_idx   (chk_idx_i),
    .chk_hit   (fifo_hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // The drain decision is combinational so the cycle that enters DRAIN already drains.
  always_comb begin
    pipe_req   = pipe_valid_i && pipe_wen_i && (pipe_rd_idx_i != '0);
    md_nz      = (md_rd_idx_i != '0);
    starved    = (starve_q == SW'(STARVE_LIMIT));
    drain      = (state_q == ST_DRAIN) || (fifo_full && pipe_req) || starved;
    grant_head = !fifo_empty && (drain || !pipe_req);
    grant_pipe = !drain && pipe_req;
    bypass     = !drain && !pipe_req && fifo_empty && md_valid_i && md_nz;
    md_ready_o = !fifo_full || grant_head;
    md_in      = md_valid_i && md_ready_o;
    push       = md_in && md_nz && !bypass;

    pipe_stall_o = drain && pipe_valid_i;
    md_busy_o    = !fifo_empty;
    rf_wen_o     = 1'b0;
    rf_waddr_o   = '0;
    rf_wdata_o   = '0;
    if (grant_head) begin
      rf_wen_o   = 1'b1;
      rf_waddr_o = head_idx;
      rf_wdata_o = head_data;
    end else if (grant_pipe) begin
      rf_wen_o   = 1'b1;
      rf_waddr_o = pipe_rd_idx_i;
      rf_wdata_o = pipe_rd_data_i;
    end else if (bypass) begin
      rf_wen_o   = 1'b1;
      rf_waddr_o = md_rd_idx_i;
      rf_wdata_o = md_rd_data_i;
    end

    chk_hit_o = (chk_idx_i != '0) &&
                (fifo_hit || ((bypass || push) && (md_rd_idx_i == chk_idx_i)));

    state_d = ST_NORMAL;
    if (drain && !fifo_empty && !(grant_head && !push && (fifo_count == 1)))
      state_d = ST_DRAIN;

    starve_d = starve_q;
    if (fifo_empty || grant_head) starve_d = '0;
    else if (!starved)            starve_d = starve_q + 1'b1;
  end

endmodule
